// File: rtl/lab3_mem_cache_mem_arbiter.sv
// Round-robin arbiter that merges two cache memory ports onto one memory port and routes
// in-order responses back using a FIFO of port IDs. The LAB3_MEM_ARB_FIXED_PRIO_EN macro selects fixed priority with port 0 winning.
package lab3_mem_cache_mem_arbiter_pkg;

  typedef struct packed {
    logic [2:0]   msg_type;
    logic [7:0]   opaque;
    logic [31:0]  addr;
    logic [3:0]   len;
    logic [127:0] data;
  } mem_req_16B_t;

  typedef struct packed {
    logic [2:0]   msg_type;
    logic [7:0]   opaque;
    logic [1:0]   test;
    logic [3:0]   len;
    logic [127:0] data;
  } mem_resp_16B_t;

endpackage

module lab3_mem_cache_mem_arbiter
  import lab3_mem_cache_mem_arbiter_pkg::*;
#(
  parameter int unsigned p_max_outstanding = 4
) (
  input  logic          clk,
  input  logic          reset,

  input  mem_req_16B_t  in0_reqstream_msg,
  input  logic          in0_reqstream_val,
  output logic          in0_reqstream_rdy,
  output mem_resp_16B_t in0_respstream_msg,
  output logic          in0_respstream_val,
  input  logic          in0_respstream_rdy,

  input  mem_req_16B_t  in1_reqstream_msg,
  input  logic          in1_reqstream_val,
  output logic          in1_reqstream_rdy,
  output mem_resp_16B_t in1_respstream_msg,
  output logic          in1_respstream_val,
  input  logic          in1_respstream_rdy,

  output mem_req_16B_t  mem_reqstream_msg,
  output logic          mem_reqstream_val,
  input  logic          mem_reqstream_rdy,
  input  mem_resp_16B_t mem_respstream_msg,
  input  logic          mem_respstream_val,
  output logic          mem_respstream_rdy
);

  localparam int unsigned addr_w = $clog2(p_max_outstanding);
  localparam int unsigned cnt_w  = addr_w + 1;
  localparam logic [cnt_w-1:0] depth = cnt_w'(p_max_outstanding);

  logic [addr_w-1:0] head;
  logic [addr_w-1:0] tail;
  logic [cnt_w-1:0]  count;
  logic              id_fifo [p_max_outstanding];

  logic grant_id;
  logic any_val;
  logic not_full;
  logic can_issue;
  logic push;
  logic pop;
  logic nonempty;
  logic dest;
  logic dest_rdy;

  // ---------------- request path ----------------
  assign any_val   = in0_reqstream_val | in1_reqstream_val;
  assign not_full  = count < depth;
  assign can_issue = mem_reqstream_rdy && not_full;

`ifdef LAB3_MEM_ARB_FIXED_PRIO_EN
  assign grant_id = !in0_reqstream_val && in1_reqstream_val;
`else
  logic prio_reg;

  // With a single valid port it always wins; prio_reg only breaks ties.
  assign grant_id = (in0_reqstream_val && in1_reqstream_val) ? prio_reg : in1_reqstream_val;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) prio_reg <= 1'b0;
    else if (push) prio_reg <= ~grant_id;
  end
`endif

  assign mem_reqstream_msg = grant_id ? in1_reqstream_msg : in0_reqstream_msg;

  // NOTE: handshake outputs are gated by reset directly so they drop the moment reset asserts,
  // even though the inputs feeding them may still be active.
  assign mem_reqstream_val = reset && any_val && not_full;
  assign in0_reqstream_rdy = reset && can_issue && !grant_id;
  assign in1_reqstream_rdy = reset && can_issue && grant_id;
  assign push              = mem_reqstream_val && mem_reqstream_rdy;

  // ---------------- response path ----------------
  assign nonempty = count != '0;
  assign dest     = id_fifo[head];
  assign dest_rdy = dest ? in1_respstream_rdy : in0_respstream_rdy;

  assign in0_respstream_val = reset && mem_respstream_val && nonempty && !dest;
  assign in1_respstream_val = reset && mem_respstream_val && nonempty && dest;
  assign mem_respstream_rdy = reset && nonempty && dest_rdy;
  assign pop                = mem_respstream_val && mem_respstream_rdy;

  assign in0_respstream_msg = mem_respstream_msg;
  assign in1_respstream_msg = mem_respstream_msg;

  // ---------------- ID FIFO ----------------
  // NOTE: the FIFO storage has no reset; validity is tracked by count, so stale entries are never read.
  always_ff @(posedge clk) begin
    if (push) id_fifo[tail] <= grant_id;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + addr_w'(1);
      if (pop)  head <= head + addr_w'(1);
      count <= count + cnt_w'(push) - cnt_w'(pop);
    end
  end

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (reset && mem_respstream_val && !nonempty)
      $error("memory response arrived with no outstanding request");
  end
`endif

endmodule

// File: tb/tb_lab3_mem_cache_mem_arbiter.sv
// Scoreboard bench for lab3_mem_cache_mem_arbiter: randomized caches and memory,
// with a queue-based reference model predicting grants, routing and ready/valid.
module tb_lab3_mem_cache_mem_arbiter;
  import lab3_mem_cache_mem_arbiter_pkg::*;

  localparam int depth = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  mem_req_16B_t  in0_reqstream_msg, in1_reqstream_msg, mem_reqstream_msg;
  logic          in0_reqstream_val, in0_reqstream_rdy, in1_reqstream_val, in1_reqstream_rdy;
  mem_resp_16B_t in0_respstream_msg, in1_respstream_msg, mem_respstream_msg;
  logic          in0_respstream_val, in0_respstream_rdy, in1_respstream_val, in1_respstream_rdy;
  logic          mem_reqstream_val, mem_reqstream_rdy, mem_respstream_val, mem_respstream_rdy;

  lab3_mem_cache_mem_arbiter #(.p_max_outstanding(depth)) dut (
    .clk                (clk),
    .reset              (reset),
    .in0_reqstream_msg  (in0_reqstream_msg),
    .in0_reqstream_val  (in0_reqstream_val),
    .in0_reqstream_rdy  (in0_reqstream_rdy),
    .in0_respstream_msg (in0_respstream_msg),
    .in0_respstream_val (in0_respstream_val),
    .in0_respstream_rdy (in0_respstream_rdy),
    .in1_reqstream_msg  (in1_reqstream_msg),
    .in1_reqstream_val  (in1_reqstream_val),
    .in1_reqstream_rdy  (in1_reqstream_rdy),
    .in1_respstream_msg (in1_respstream_msg),
    .in1_respstream_val (in1_respstream_val),
    .in1_respstream_rdy (in1_respstream_rdy),
    .mem_reqstream_msg  (mem_reqstream_msg),
    .mem_reqstream_val  (mem_reqstream_val),
    .mem_reqstream_rdy  (mem_reqstream_rdy),
    .mem_respstream_msg (mem_respstream_msg),
    .mem_respstream_val (mem_respstream_val),
    .mem_respstream_rdy (mem_respstream_rdy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errs   = 0;

  // Reference model state: ports of outstanding requests in issue order, and the tie-break port.
  bit            pend[$];
  bit            prio_m = 1'b0;
  // Scoreboard queues of expected handshake payloads.
  mem_req_16B_t  exp_req_q[$];
  mem_resp_16B_t exp_r0_q[$];
  mem_resp_16B_t exp_r1_q[$];
  // Main-memory environment: requests accepted and not yet answered.
  mem_req_16B_t  mem_q[$];

  task automatic check(input string name, input logic [191:0] act, input logic [191:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic mem_req_16B_t rand_req();
    mem_req_16B_t r;
    r.msg_type = 3'($urandom_range(1));
    r.opaque   = 8'($urandom);
    r.addr     = $urandom;
    r.len      = 4'd0;
    r.data     = {$urandom, $urandom, $urandom, $urandom};
    return r;
  endfunction

  function automatic mem_resp_16B_t make_resp(input mem_req_16B_t q);
    mem_resp_16B_t r;
    r.msg_type = q.msg_type;
    r.opaque   = q.opaque;
    r.test     = 2'd0;
    r.len      = 4'd0;
    r.data     = {$urandom, $urandom, $urandom, $urandom};
    return r;
  endfunction

  // One cycle of stimulus; arguments are percent probabilities of each valid/ready.
  task automatic drive(input int p0, input int p1, input int pmr, input int pr0, input int pr1, input int pmv);
    @(posedge clk); #1;
    in0_reqstream_val  = $urandom_range(99) < p0;
    in1_reqstream_val  = $urandom_range(99) < p1;
    in0_reqstream_msg  = rand_req();
    in1_reqstream_msg  = rand_req();
    mem_reqstream_rdy  = $urandom_range(99) < pmr;
    in0_respstream_rdy = $urandom_range(99) < pr0;
    in1_respstream_rdy = $urandom_range(99) < pr1;
    mem_respstream_val = (mem_q.size() > 0) && ($urandom_range(99) < pmv);
    if (mem_q.size() > 0) mem_respstream_msg = make_resp(mem_q[0]);
  endtask

  // Reference model: predict every ready/valid from the pre-edge state, then advance.
  always @(negedge clk) begin
    if (!reset) begin
      check("reset_outputs",
            192'({mem_reqstream_val, in0_reqstream_rdy, in1_reqstream_rdy,
                  in0_respstream_val, in1_respstream_val, mem_respstream_rdy}), 192'(0));
      pend.delete(); exp_req_q.delete(); exp_r0_q.delete(); exp_r1_q.delete(); mem_q.delete();
      prio_m = 1'b0;
    end else begin
      bit full, any, win, exp_mval, nonempty, front, exp_rrdy;
      full = pend.size() >= depth;
      any  = in0_reqstream_val || in1_reqstream_val;
`ifdef LAB3_MEM_ARB_FIXED_PRIO_EN
      win = !in0_reqstream_val;
`else
      win = (in0_reqstream_val && in1_reqstream_val) ? prio_m : in1_reqstream_val;
`endif
      exp_mval = any && !full;
      check("mem_req_val", 192'(mem_reqstream_val), 192'(exp_mval));
      if (any) begin
        check("in0_req_rdy", 192'(in0_reqstream_rdy), 192'(mem_reqstream_rdy && !full && !win));
        check("in1_req_rdy", 192'(in1_reqstream_rdy), 192'(mem_reqstream_rdy && !full && win));
      end
      nonempty = pend.size() > 0;
      front    = nonempty ? pend[0] : 1'b0;
      exp_rrdy = nonempty && (front ? in1_respstream_rdy : in0_respstream_rdy);
      check("in0_resp_val", 192'(in0_respstream_val), 192'(mem_respstream_val && nonempty && !front));
      check("in1_resp_val", 192'(in1_respstream_val), 192'(mem_respstream_val && nonempty && front));
      check("mem_resp_rdy", 192'(mem_respstream_rdy), 192'(exp_rrdy));

      if (exp_mval && mem_reqstream_rdy) begin
        exp_req_q.push_back(win ? in1_reqstream_msg : in0_reqstream_msg);
        pend.push_back(win);
        prio_m = ~win;
      end
      if (exp_rrdy && mem_respstream_val) begin
        if (front) exp_r1_q.push_back(mem_respstream_msg);
        else       exp_r0_q.push_back(mem_respstream_msg);
        void'(pend.pop_front());
      end

      if (mem_reqstream_val && mem_reqstream_rdy) mem_q.push_back(mem_reqstream_msg);
      if (mem_respstream_val && mem_respstream_rdy && mem_q.size() > 0) void'(mem_q.pop_front());
    end
  end

  // Monitor: compare payloads whenever the DUT completes a handshake.
  always @(negedge clk) begin
    #1;
    if (reset) begin
      if (mem_reqstream_val && mem_reqstream_rdy) begin
        if (exp_req_q.size() == 0) begin
          n_checks++; n_errs++;
          $display("FAIL mem_req_unexpected: got request %h expected none", mem_reqstream_msg);
        end else check("mem_req_msg", 192'(mem_reqstream_msg), 192'(exp_req_q.pop_front()));
      end
      if (in0_respstream_val && in0_respstream_rdy) begin
        if (exp_r0_q.size() == 0) begin
          n_checks++; n_errs++;
          $display("FAIL resp0_unexpected: got response %h expected none", in0_respstream_msg);
        end else check("resp0_msg", 192'(in0_respstream_msg), 192'(exp_r0_q.pop_front()));
      end
      if (in1_respstream_val && in1_respstream_rdy) begin
        if (exp_r1_q.size() == 0) begin
          n_checks++; n_errs++;
          $display("FAIL resp1_unexpected: got response %h expected none", in1_respstream_msg);
        end else check("resp1_msg", 192'(in1_respstream_msg), 192'(exp_r1_q.pop_front()));
      end
    end
  end

  initial begin
    in0_reqstream_val = 0; in1_reqstream_val = 0; mem_reqstream_rdy = 0;
    in0_respstream_rdy = 0; in1_respstream_rdy = 0; mem_respstream_val = 0;
    in0_reqstream_msg = '0; in1_reqstream_msg = '0; mem_respstream_msg = '0;
    #2 reset = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;

    // Single read from port 0 at 0x1000, then let it return.
    drive(100, 0, 100, 100, 100, 0);
    in0_reqstream_msg.addr = 32'h1000;
    in0_reqstream_msg.msg_type = 3'd0;
    repeat (5) drive(0, 0, 100, 100, 100, 100);

    // Both ports streaming with everything ready: alternating grants and returns.
    repeat (8) drive(100, 100, 100, 100, 100, 100);

    // Fill to the outstanding limit, then release one response at a time.
    repeat (8) drive(100, 100, 100, 100, 100, 0);
    drive(100, 100, 100, 100, 100, 100);
    repeat (3) drive(100, 100, 100, 100, 100, 0);
    repeat (10) drive(0, 0, 100, 100, 100, 100);

    // Port 1 response stalls hold up everything behind it.
    repeat (30) drive(70, 70, 80, 100, 0, 80);
    repeat (10) drive(0, 0, 100, 100, 100, 100);

    // Long random run with pointer wraps and simultaneous push/pop.
    repeat (3000) drive(60, 60, 70, 70, 70, 60);

    // Reset with requests outstanding and traffic active.
    repeat (6) drive(100, 100, 100, 100, 100, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    in0_reqstream_val = 1; in1_reqstream_val = 1; mem_reqstream_rdy = 1;
    in0_respstream_rdy = 1; in1_respstream_rdy = 1; mem_respstream_val = 1;
    @(posedge clk); #1;
    mem_respstream_val = 0;
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (8) drive(100, 100, 100, 100, 100, 100);
    repeat (500) drive(60, 60, 70, 70, 70, 60);

    repeat (20) drive(0, 0, 100, 100, 100, 100);
    @(negedge clk); #2;
    check("drain_empty", 192'(exp_req_q.size() + exp_r0_q.size() + exp_r1_q.size() + pend.size()), 192'(0));

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
